// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC-driven fetch front end with credit-limited issue, in-flight PC tracking and a decode-side FIFO
// Ports: Clk_Core/Rst_Core_N clock and async active-low reset; Program_Count/Flush/Run connect to the PC;
// Imem_Req_* issue fetches; Imem_Rsp_* return in-order instructions; Instr_* present {PC, instruction} to decode.
module instr_fetch_queue #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  input  logic [DWIDTH-1:0] Program_Count,
  input  logic              Flush,
  output logic              Run,
  output logic              Imem_Req_Valid,
  input  logic              Imem_Req_Ready,
  output logic [DWIDTH-1:0] Imem_Req_Addr,
  input  logic              Imem_Rsp_Valid,
  input  logic [DWIDTH-1:0] Imem_Rsp_Data,
  output logic              Instr_Valid,
  input  logic              Instr_Ready,
  output logic [DWIDTH-1:0] Instr_Data,
  output logic [DWIDTH-1:0] Instr_PC
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
  logic [CW-1:0] out_q, out_d, stale_q, stale_d, cnt_q, cnt_d;
  logic [AW-1:0] fw_q, fw_d, fr_q, fr_d, qw_q, qw_d, qr_q, qr_d;
  logic [DWIDTH-1:0] fpc_q [DEPTH];
  logic [DWIDTH-1:0] qpc_q [DEPTH];
  logic [DWIDTH-1:0] qdat_q [DEPTH];
  logic [CW:0] used;
  logic rsp, enq, deq;
  // every outstanding fetch reserves a queue slot, so the queue can never overflow
  assign used           = {1'b0, out_q} + {1'b0, cnt_q};
  assign Imem_Req_Valid = !Flush && (used < LIMIT);
  assign Run            = Imem_Req_Valid && Imem_Req_Ready;
  assign Imem_Req_Addr  = Program_Count;
  // a response with nothing outstanding is a protocol error and is ignored entirely
  assign rsp         = Imem_Rsp_Valid && (out_q != '0);
  assign enq         = rsp && !Flush && (stale_q == '0);
  assign Instr_Valid = (cnt_q != '0) && !Flush;
  assign deq         = Instr_Valid && Instr_Ready;
  assign Instr_Data  = qdat_q[qr_q];
  assign Instr_PC    = qpc_q[qr_q];
  always_comb begin
    out_d   = out_q + CW'(Run) - CW'(rsp);
    stale_d = Flush ? out_q - CW'(rsp) : stale_q - CW'(rsp && (stale_q != '0));
    cnt_d   = Flush ? '0 : cnt_q + CW'(enq) - CW'(deq);
    fw_d    = fw_q + AW'(Run);
    fr_d    = fr_q + AW'(rsp);
    qw_d    = qw_q + AW'(enq);
    qr_d    = Flush ? qw_q : qr_q + AW'(deq);
  end
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      out_q   <= '0;
      stale_q <= '0;
      cnt_q   <= '0;
      fw_q    <= '0;
      fr_q    <= '0;
      qw_q    <= '0;
      qr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fpc_q[i]  <= '0;
        qpc_q[i]  <= '0;
        qdat_q[i] <= '0;
      end
    end else begin
      out_q   <= out_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
      fw_q    <= fw_d;
      fr_q    <= fr_d;
      qw_q    <= qw_d;
      qr_q    <= qr_d;
      if (Run) fpc_q[fw_q] <= Imem_Req_Addr;
      if (enq) begin
        qpc_q[qw_q]  <= fpc_q[fr_q];
        qdat_q[qw_q] <= Imem_Rsp_Data;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed and random checks of instr_fetch_queue against a queue-based reference model
module tb_instr_fetch_queue;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] Program_Count = '0;
  logic Flush = 1'b0;
  logic Run;
  logic Imem_Req_Valid;
  logic Imem_Req_Ready = 1'b0;
  logic [DW-1:0] Imem_Req_Addr;
  logic Imem_Rsp_Valid = 1'b0;
  logic [DW-1:0] Imem_Rsp_Data = '0;
  logic Instr_Valid;
  logic Instr_Ready = 1'b0;
  logic [DW-1:0] Instr_Data;
  logic [DW-1:0] Instr_PC;
  always #5 clk = ~clk;
  instr_fetch_queue #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .Clk_Core(clk), .Rst_Core_N(rst_n), .Program_Count(Program_Count), .Flush(Flush), .Run(Run),
    .Imem_Req_Valid(Imem_Req_Valid), .Imem_Req_Ready(Imem_Req_Ready), .Imem_Req_Addr(Imem_Req_Addr),
    .Imem_Rsp_Valid(Imem_Rsp_Valid), .Imem_Rsp_Data(Imem_Rsp_Data), .Instr_Valid(Instr_Valid),
    .Instr_Ready(Instr_Ready), .Instr_Data(Instr_Data), .Instr_PC(Instr_PC)
  );
  typedef struct {logic [31:0] pc; bit stale;} infl_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
  typedef struct {int due; logic [31:0] data;} mrsp_t;
  infl_t infl[$];
  ent_t iq[$];
  mrsp_t pend[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int last_due = -1;
  int exp_stale;
  int tries;
  logic [31:0] pc = '0;
  logic [31:0] tgt;
  bit fl;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit f, input logic [31:0] t, input bit rdy, input bit irdy, input bit stray = 1'b0);
    bit rv, ereq, erun, eiv;
    logic [31:0] rd;
    infl_t e;
    ent_t x;
    mrsp_t m;
    @(negedge clk);
    rv = 1'b0;
    rd = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rv = 1'b1;
      rd = pend[0].data;
      pend.delete(0);
    end
    if (stray) begin
      rv = 1'b1;
      rd = 32'hDEAD_BEEF;
    end
    Program_Count = pc;
    Flush = f;
    Imem_Req_Ready = rdy;
    Instr_Ready = irdy;
    Imem_Rsp_Valid = rv;
    Imem_Rsp_Data = rd;
    #1;
    ereq = !f && (infl.size() + iq.size() < DEPTH);
    erun = ereq && rdy;
    eiv = iq.size() > 0 && !f;
    chk("req_valid", Imem_Req_Valid, ereq);
    chk("run", Run, erun);
    chk("req_addr", Imem_Req_Addr, pc);
    chk("instr_valid", Instr_Valid, eiv);
    if (eiv) begin
      chk("instr_pc", Instr_PC, iq[0].pc);
      chk("instr_data", Instr_Data, iq[0].data);
    end
    if (eiv && irdy) iq.delete(0);
    if (rv && infl.size() > 0) begin
      e = infl[0];
      infl.delete(0);
      if (!f && !e.stale) begin
        x.pc = e.pc;
        x.data = rd;
        iq.push_back(x);
      end
    end
    if (f) begin
      iq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
    end
    if (erun) begin
      e.pc = pc;
      e.stale = 1'b0;
      infl.push_back(e);
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      m.due = last_due;
      m.data = mem(pc);
      pend.push_back(m);
    end
    if (f) pc = t;
    else if (erun) pc = pc + 4;
    @(posedge clk);
    cyc++;
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_req_valid"}, Imem_Req_Valid, 1);
    chk({tag, "_run"}, Run, 1);
    chk({tag, "_instr_valid"}, Instr_Valid, 0);
    chk({tag, "_instr_data"}, Instr_Data, 0);
    chk({tag, "_instr_pc"}, Instr_PC, 0);
  endtask
  initial begin
    Imem_Req_Ready = 1'b1;
    #1;
    reset_checks("rst");
    Imem_Req_Ready = 1'b0;
    #1;
    chk("rst_run_follows_ready", Run, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 1;
    repeat (12) step(0, 0, 1, 1);
    repeat (8) step(0, 0, 1, 0);
    #1;
    chk("backpressure_count", dut.cnt_q, 4);
    chk("backpressure_outstanding", dut.out_q, 0);
    repeat (10) step(0, 0, 1, 1);
    repeat (6) step(0, 0, 0, 1);
    lat = 3;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    #1;
    chk("preflush_outstanding", dut.out_q, 2);
    chk("preflush_count", dut.cnt_q, 1);
    step(1, 32'h100, 1, 0);
    #1;
    chk("flush_stale", dut.stale_q, 2);
    repeat (10) step(0, 0, 1, 1);
    lat = 2;
    repeat (6) step(0, 0, 1, 1);
    tries = 0;
    while (!(pend.size() > 0 && pend[0].due == cyc) && tries < 10) begin
      step(0, 0, 1, 1);
      tries++;
    end
    chk("coincident_rsp_found", tries < 10, 1);
    exp_stale = infl.size() - 1;
    step(1, 32'h200, 1, 1);
    #1;
    chk("coincident_stale", dut.stale_q, exp_stale);
    repeat (8) step(0, 0, 1, 1);
    lat = 1;
    repeat (5) step(0, 0, 0, 1);
    repeat (8) step(0, 0, 1, 1);
    repeat (4) step(0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    #1;
    chk("stray_outstanding", dut.out_q, infl.size());
    chk("stray_count", dut.cnt_q, iq.size());
    repeat (300) begin
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 3);
      fl = ($urandom_range(0, 19) == 0);
      tgt = 32'($urandom_range(0, 4095)) << 2;
      step(fl, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    end
    lat = 1;
    repeat (4) step(0, 0, 1, 1);
    @(negedge clk);
    Flush = 1'b0;
    Imem_Rsp_Valid = 1'b0;
    Imem_Req_Ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    infl.delete();
    iq.delete();
    pend.delete();
    pc = '0;
    last_due = -1;
    Imem_Req_Ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step(0, 0, 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
